// File: rtl/counter_24.sv
`default_nettype none
// ============================================================================
//  Module   : counter_24
//  Purpose  : Two-digit BCD hour counter, modulus 24 (00..23).
//             Advances one step on every rising clk edge with en high,
//             wrapping 23 -> 00. Any illegal BCD/hour code is replaced by
//             00 on the next enabled edge.
//  Ports    : clk  - rising-edge clock
//             cr   - synchronous clear, active-high, highest priority
//             en   - count enable, active-high
//             data - registered BCD value {tens[3:0], ones[3:0]}
//             co   - combinational carry-out, high while the next
//                    enabled edge will wrap 23 -> 00
//  Revision : 1.0  initial release
// ============================================================================
module counter_24 (
  input  logic       clk,
  input  logic       cr,
  input  logic       en,
  output logic [7:0] data,
  output logic       co
);

  localparam logic [3:0] C_ONES_MAX = 4'd9;
  localparam logic [3:0] C_TENS_MAX = 4'd2;
  localparam logic [3:0] C_LAST_HR  = 4'd3;   // highest ones digit when tens==2
  localparam logic [7:0] C_WRAP_VAL = 8'h23;
  localparam logic [7:0] C_ZERO     = 8'h00;

  logic [7:0] r_data;
  logic [3:0] w_ones;
  logic [3:0] w_tens;
  logic       w_legal;
  logic       w_at_max;
  logic [7:0] w_next;

  assign w_ones = r_data[3:0];
  assign w_tens = r_data[7:4];

  // A code is legal only when it names an hour 00..23 in BCD.
  always_comb begin
    w_legal = 1'b0;
    if (w_tens < C_TENS_MAX) begin
      w_legal = (w_ones <= C_ONES_MAX);
    end else if (w_tens == C_TENS_MAX) begin
      w_legal = (w_ones <= C_LAST_HR);
    end
  end

  assign w_at_max = (r_data == C_WRAP_VAL);

  // Next-value decode. The wrap and illegal cases both collapse to 00, and
  // the ones->tens carry is only taken from a legal state, so tens never
  // exceeds 2 and no digit ever carries outside its own nibble.
  always_comb begin
    w_next = C_ZERO;
    if (!w_legal || w_at_max) begin
      w_next = C_ZERO;
    end else if (w_ones == C_ONES_MAX) begin
      w_next = {w_tens + 4'd1, 4'd0};
    end else begin
      w_next = {w_tens, w_ones + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      r_data <= C_ZERO;
    end else if (en) begin
      r_data <= w_next;
    end
  end

  assign data = r_data;

  // Equality with 23 already excludes every illegal code, so co stays low
  // in illegal states without an extra legality term.
  assign co = en & ~cr & w_at_max;

endmodule
`default_nettype wire

// File: tb/tb_counter_24.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_24
//  Purpose  : Directed self-checking bench for counter_24.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_24;

  logic       clk;
  logic       cr;
  logic       en;
  logic [7:0] data;
  logic       co;

  int checks = 0;
  int errors = 0;

  counter_24 dut (
    .clk  (clk),
    .cr   (cr),
    .en   (en),
    .data (data),
    .co   (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    cr = 1'b1;
    en = 1'b0;

    // Clear from unknown power-up state.
    step();
    chk("reset_data", data, 8'h00);
    chk("reset_co", {7'd0, co}, 8'h00);

    // Full cycle: 24 enabled edges, 00 -> 23 -> 00.
    cr = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      chk($sformatf("seq_co_before_%0d", i), {7'd0, co},
          ((i - 1) == 23) ? 8'h01 : 8'h00);
      step();
      chk($sformatf("seq_data_%0d", i), data, to_bcd(i % 24));
    end

    // 09 -> 10 and 19 -> 20.
    cr = 1'b1; step(); cr = 1'b0;
    steps(9);
    chk("at_09", data, 8'h09);
    step();
    chk("09_to_10", data, 8'h10);
    steps(9);
    chk("at_19", data, 8'h19);
    step();
    chk("19_to_20", data, 8'h20);

    // At 23: en=0 holds and co=0; en=1 gives co=1 then 00.
    steps(3);
    chk("at_23", data, 8'h23);
    en = 1'b0;
    #1;
    chk("co_23_en0", {7'd0, co}, 8'h00);
    step();
    chk("hold_23", data, 8'h23);
    en = 1'b1;
    #1;
    chk("co_23_en1", {7'd0, co}, 8'h01);
    step();
    chk("wrap_23_00", data, 8'h00);

    // Hold at 15 for five edges, then advance to 16.
    steps(15);
    chk("at_15", data, 8'h15);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_15_%0d", i), data, 8'h15);
    end
    en = 1'b1;
    step();
    chk("15_to_16", data, 8'h16);

    // At 17, cr and en together: clear wins, co low.
    step();
    chk("at_17", data, 8'h17);
    cr = 1'b1;
    #1;
    chk("co_clear_en", {7'd0, co}, 8'h00);
    step();
    chk("clear_wins", data, 8'h00);

    // cr rising between edges leaves data alone until the edge.
    cr = 1'b0;
    steps(3);
    chk("at_03", data, 8'h03);
    @(negedge clk);
    cr = 1'b1;
    en = 1'b0;
    #1;
    chk("cr_async_hold", data, 8'h03);
    step();
    chk("cr_edge_clear", data, 8'h00);
    cr = 1'b0;
    en = 1'b1;
    step();
    chk("resume_01", data, 8'h01);

    // Illegal states load 00 on the next enabled edge; co stays low.
    force dut.r_data = 8'h2A;
    #1;
    release dut.r_data;
    #1;
    chk("illegal_2A_co", {7'd0, co}, 8'h00);
    step();
    chk("illegal_2A_clr", data, 8'h00);

    force dut.r_data = 8'h3F;
    #1;
    release dut.r_data;
    #1;
    chk("illegal_3F_co", {7'd0, co}, 8'h00);
    step();
    chk("illegal_3F_clr", data, 8'h00);

    force dut.r_data = 8'h24;
    #1;
    release dut.r_data;
    #1;
    chk("illegal_24_co", {7'd0, co}, 8'h00);
    step();
    chk("illegal_24_clr", data, 8'h00);

    force dut.r_data = 8'h1A;
    #1;
    release dut.r_data;
    step();
    chk("illegal_1A_clr", data, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_24.md
COUNTER_24 -- requirements
Module: counter_24

Parameters
REQ-001 None; the modulus (24) and the BCD encoding are fixed.

Interface
REQ-002 clk   input   1  rising-edge clock; all state changes on the rising edge only.
REQ-003 cr    input   1  clear; synchronous, active-high; highest priority.
REQ-004 en    input   1  count enable; active-high; sampled on the rising clk edge.
REQ-005 data  output  8  registered BCD hour value: data[7:4] = tens digit (0-2), data[3:0] = ones digit (0-9).
REQ-006 co    output  1  combinational carry-out; high during the cycle in which the counter will wrap 23->00.

Function
REQ-007 Sequence on enabled edges: 00,01,...,09,10,...,19,20,21,22,23,00,... (BCD, decimal 0-23).
REQ-008 Edge priority: cr=1 -> data<=8'h00; else en=1 -> advance; else hold.
REQ-009 Advance rules:
- data==8'h23: next value is 8'h00.
- ones==9: ones<=0, tens<=tens+1.
- otherwise: ones<=ones+1, tens unchanged.
REQ-010 Counting latency: data reflects each advance one clk edge after en is sampled high; no pipeline.
REQ-011 en=0 holds data indefinitely; no internal prescaler; one step per enabled edge.
REQ-012 co = en & ~cr & (data==8'h23); purely combinational from current state and inputs.
REQ-013 Self-correction: any illegal state (ones>9, tens>2, or tens==2 with ones>3) SHALL load 8'h00 on the next enabled edge; co SHALL stay 0 in illegal states.
REQ-014 No arithmetic overflow paths: each digit is a 4-bit field and never carries outside its nibble.
REQ-015 cr and en both high: clear wins; data<=8'h00; co=0.

Reset
REQ-016 cr is synchronous: data SHALL NOT change between clock edges when cr rises.
REQ-017 After any edge with cr=1: data=8'h00, co=0.
REQ-018 Mid-count clear at any value returns to 8'h00 on the same edge; counting resumes from 00 on the first edge with cr=0 and en=1.
REQ-019 Power-up value before the first clear is undefined; the bench SHALL apply cr=1 for at least one edge first.

Verification
REQ-020 cr=1 for 1 edge, then cr=0, en=1 for 24 edges -> data steps 00,01,...,09,10,...,19,20,21,22,23, then 00 on the 24th edge.
REQ-021 Counter at 09 with en=1 -> next edge data=10; counter at 19 -> next edge data=20.
REQ-022 Counter at 23 with en=1 -> co=1 before the edge and data=00 after it; counter at 23 with en=0 -> co=0 and data holds 23.
REQ-023 Counter at 15 with en=0 for 5 edges -> data stays 15; en=1 for one edge -> data=16.
REQ-024 Counter at 17 with cr=1 and en=1 for one edge -> data=00 and co=0; cr rising between edges -> no change until the edge.
REQ-025 Force illegal state 8'h2A (or 8'h3F) with en=1 -> data=00 after one edge and co=0 beforehand.
